seq_mult4: RTL

SEQ_MULT4 -- requirements
Module: seq_mult4

---
 rtl/seq_mult4_pkg.sv | 15 +
 rtl/seq_mult4_pp_row.sv | 16 +
 rtl/seq_mult4.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_mult4_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult4_pkg;

    // Operand width used when the multiplier is instantiated without an override.
    localparam int DEFAULT_W = 4;

    // Control states: waiting for operands, stepping through multiplier bits,
    // and holding a finished product until it is taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult4_pp_row.sv
// One partial-product row: conditionally add the multiplicand to the running
// upper half of the accumulator. The extra result bit is the carry out.
module pp_row
    import seq_mult4_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic         b_bit,
    input  logic [W-1:0] prev,
    output logic [W:0]   sum
);

    assign sum = {1'b0, a & {W{b_bit}}} + {1'b0, prev};

endmodule

// File: rtl/seq_mult4.sv
// Sequential unsigned multiplier: one multiplier bit per clock, LSB first,
// with a ready/valid handshake on both sides and a synchronous abort.
module seq_mult4
    import seq_mult4_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int             CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    state_t         state;
    state_t         next_state;
    logic           accept;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   acc_lo;
    logic [CNT_W-1:0] cnt;
    logic [W:0]     row_sum;

    // The single adder row is shared by every RUN cycle; the multiplier
    // register shifts right so bit 0 is always the bit being processed.
    pp_row #(
        .W(W)
    ) u_row (
        .a    (a_reg),
        .b_bit(b_reg[0]),
        .prev (acc_hi),
        .sum  (row_sum)
    );

    // Next-state decode; abort wins over both acceptance and the output handshake.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && !abort) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign p         = out_valid ? {acc_hi, acc_lo} : '0;

    // State register plus datapath: load operands on accept, then shift-add
    // one bit per RUN cycle with the freed LSB moving into the low half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_reg  <= a;
                b_reg  <= b;
                acc_hi <= '0;
                acc_lo <= '0;
                cnt    <= '0;
            end else if (state == RUN && !abort) begin
                acc_hi <= row_sum[W:1];
                acc_lo <= {row_sum[0], acc_lo[W-1:1]};
                b_reg  <= b_reg >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
